scr1_ahb_sram_bridge: RTL and testbench
=======================================

SCR1_AHB_SRAM_BRIDGE -- requirements
Module: scr1_ahb_sram_bridge

Interface
REQ-001 Parameter AW, default 20, SRAM byte-address width; window is 0 .. 2**AW-1.
REQ-002 Parameter STALL_W, default 32, width of the wait-state pattern.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-high.
REQ-005 stall_pattern  in  STALL_W  wait-state pattern; 1 = ready allowed this data-phase cycle.
REQ-006 htrans  in  2  AHB-lite transfer type.
REQ-007 haddr  in  32  AHB address.
REQ-008 hsize  in  3  AHB size: 0 = byte, 1 = half, 2 = word.
REQ-009 hwrite  in  1  AHB write flag.
REQ-010 hwdata  in  32  AHB write data, driven in data phase.
REQ-011 hready  out  1  transfer-done / address-accept.
REQ-012 hrdata  out  32  read data.
REQ-013 hresp  out  1  0 = OKAY, 1 = ERROR.
REQ-014 mem_req  out  1  one-cycle SRAM access strobe.
REQ-015 mem_we  out  1  SRAM write enable, qualified by mem_req.
REQ-016 mem_addr  out  AW-2  SRAM word address.
REQ-017 mem_be  out  4  byte enables.
REQ-018 mem_wdata  out  32  SRAM write data.
REQ-019 mem_rdata  in  32  SRAM read data, valid the cycle after a read mem_req.

Function
REQ-020 An address phase is accepted when htrans[1]=1 and hready=1; IDLE/BUSY with hready=1 are ignored.
REQ-021 FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_WAIT, ERR1, ERR2.
REQ-022 On acceptance, latch haddr, hsize and hwrite, then go to: ERR1 if the transfer is illegal, otherwise RD_ISSUE if a read, otherwise WR_WAIT.
REQ-023 Illegal transfer: haddr >= 2**AW; or hsize > 2; or half with haddr[0]=1; or word with haddr[1:0]!=0.
REQ-024 ERR1: hready=0, hresp=1. ERR2: hready=1, hresp=1. ERR2 -> IDLE. No mem_req is issued.
REQ-025 RD_ISSUE: mem_req=1, mem_we=0, hready=0; next state RD_WAIT.
REQ-026 RD_WAIT: hrdata register loads mem_rdata in the first RD_WAIT cycle; hready = current stall bit; on hready=1 the transfer completes.
REQ-027 WR_WAIT: hready = current stall bit; in the completing cycle mem_req=1, mem_we=1, mem_wdata=hwdata.
REQ-028 mem_be: byte = 1 << a[1:0]; half = 0011 << a[1:0]; word = 1111.
REQ-029 mem_addr = latched address [AW-1:2].
REQ-030 Stall bit = pattern register MSB. The register rotates left by one on every RD_WAIT or WR_WAIT cycle and holds otherwise.
REQ-031 The pattern register reloads from stall_pattern at reset and on every IDLE cycle.
REQ-032 A pattern of all zeros is treated as all ones (no deadlock).
REQ-033 Pipelining: in a completing cycle (hready=1, hresp=0), a new address phase is accepted in the same cycle. The FSM moves directly to the next transfer's state, with no IDLE bubble.
REQ-034 In all other states and cycles: hready=1 in IDLE, hresp=0.
REQ-035 hrdata holds its last value until the next read's RD_WAIT load.
REQ-036 Minimum latency: read 2 data-phase cycles; write 1 data-phase cycle.

Reset
REQ-037 While rst=1 the block SHALL hold: state=IDLE, hready=1, hresp=0, hrdata=0, mem_req=0, mem_we=0, mem_be=0, pattern register = stall_pattern.
REQ-038 Reset asserted mid-transfer SHALL abort the transfer with no mem_req issued after assertion.

Structure
REQ-039 Package scr1_ahb_sram_pkg SHALL hold the FSM state enum, the HTRANS codes (IDLE/BUSY/NONSEQ/SEQ) and the HSIZE codes.
REQ-040 The pattern rotator SHALL be a sub-module scr1_ahb_stall_gen: load, rotate enable, zero-to-ones substitution, stall-bit output.

Verification
REQ-041 stall_pattern=FFFFFFFF; write word 0x100 = 0xDEADBEEF, then read 0x100 -> write completes in 1 cycle; read hready high on the 2nd data-phase cycle; hrdata=0xDEADBEEF.
REQ-042 Byte write 0xAB to 0x203 -> mem_be=1000; a following word read of 0x200 returns 0xAB in byte lane 3.
REQ-043 stall_pattern=A0000000, word read -> hready pattern 0,1,0,1 across data-phase cycles; completes on the first 1 after RD_ISSUE; mem_req pulses exactly once.
REQ-044 Half read at 0x101, then word read at 2**AW -> each gives ERR1/ERR2 (hready 0 then 1, hresp 1 for both cycles); no mem_req.
REQ-045 Back-to-back NONSEQ writes 0x0, 0x4, 0x8 with pattern all ones -> three mem_req cycles in three consecutive cycles, correct addresses and data.
REQ-046 stall_pattern=0 -> behaves as all ones. Also: rst asserted in RD_WAIT -> next cycle shows hready=1, mem_req=0, hrdata=0.

Source files
------------

// File: rtl/scr1_ahb_sram_pkg.sv
// Shared types for the AHB-lite to single-port SRAM bridge: FSM states,
// AHB transfer/size codes and the byte-enable helper.
package scr1_ahb_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_WAIT  = 3'd3,
    ST_ERR1     = 3'd4,
    ST_ERR2     = 3'd5
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Lane mask for a legal (already alignment-checked) transfer.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << a;
      HSIZE_HALF: be = 4'b0011 << a;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/scr1_ahb_stall_gen.sv
// Wait-state pattern rotator: the MSB of the pattern register is the
// "ready allowed" bit for the current data-phase cycle.
module scr1_ahb_stall_gen #(
  parameter int STALL_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] pattern_i,
  input  logic               load_i,
  input  logic               rot_i,
  output logic               stall_bit_o
);

  logic [STALL_W-1:0] pat_q;
  logic [STALL_W-1:0] pat_d;
  logic [STALL_W-1:0] pat_eff;

  // An all-zero pattern would never grant ready, so it means "no wait states".
  assign pat_eff = (pattern_i == '0) ? '1 : pattern_i;

  always_comb begin
    pat_d = pat_q;
    if (load_i) begin
      pat_d = pat_eff;
    end else if (rot_i) begin
      pat_d = {pat_q[STALL_W-2:0], pat_q[STALL_W-1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= pat_eff;
    end else begin
      pat_q <= pat_d;
    end
  end

  assign stall_bit_o = pat_q[STALL_W-1];

endmodule

// File: rtl/scr1_ahb_sram_bridge.sv
// AHB-lite slave in front of a single-port SRAM with one-cycle read latency
// and a programmable wait-state pattern.
module scr1_ahb_sram_bridge
  import scr1_ahb_sram_pkg::*;
#(
  parameter int AW      = 20,
  parameter int STALL_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_pattern,
  input  logic [1:0]         htrans,
  input  logic [31:0]        haddr,
  input  logic [2:0]         hsize,
  input  logic               hwrite,
  input  logic [31:0]        hwdata,
  output logic               hready,
  output logic [31:0]        hrdata,
  output logic               hresp,
  output logic               mem_req,
  output logic               mem_we,
  output logic [AW-3:0]      mem_addr,
  output logic [3:0]         mem_be,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output state_e             dbg_state_o
);

  state_e        state_q;
  state_e        state_d;
  logic [AW-1:0] addr_q;
  logic [2:0]    size_q;
  logic          rd_first_q;
  logic [31:0]   hrdata_q;
  logic          stall;
  logic          accept;
  logic          illegal;

  scr1_ahb_stall_gen #(.STALL_W(STALL_W)) u_stall (
    .clk         (clk),
    .rst         (rst),
    .pattern_i   (stall_pattern),
    .load_i      (state_q == ST_IDLE),
    .rot_i       ((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT)),
    .stall_bit_o (stall)
  );

  // Handshake: an address phase is taken when htrans is NONSEQ/SEQ in a cycle
  // where hready=1 and hresp=0; a data phase ends in the cycle hready=1.
  always_comb begin
    hready  = 1'b1;
    hresp   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_RD_ISSUE: begin
        hready  = 1'b0;
        mem_req = 1'b1;
      end
      ST_RD_WAIT: hready = stall;
      ST_WR_WAIT: begin
        hready  = stall;
        mem_req = stall;
        mem_we  = stall;
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  assign accept  = ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)) && hready && !hresp;
  assign illegal = (|haddr[31:AW]) || (hsize > HSIZE_WORD) ||
                   ((hsize == HSIZE_HALF) && haddr[0]) ||
                   ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT:  if (stall) state_d = ST_IDLE;
      ST_WR_WAIT:  if (stall) state_d = ST_IDLE;
      ST_ERR1:     state_d = ST_ERR2;
      ST_ERR2:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // A completing cycle may carry the next address phase: no idle bubble.
    if (accept) begin
      state_d = illegal ? ST_ERR1 : (hwrite ? ST_WR_WAIT : ST_RD_ISSUE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= HSIZE_BYTE;
      rd_first_q <= 1'b0;
      hrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_first_q <= (state_q == ST_RD_ISSUE);
      if (accept) begin
        addr_q <= haddr[AW-1:0];
        size_q <= hsize;
      end
      if (rd_first_q) begin
        hrdata_q <= mem_rdata;
      end
    end
  end

  // The SRAM word is forwarded during the load cycle so a zero-wait read
  // completes with the fresh data rather than the previous value.
  assign hrdata      = rd_first_q ? mem_rdata : hrdata_q;
  assign mem_addr    = addr_q[AW-1:2];
  assign mem_be      = mem_req ? byte_en(size_q, addr_q[1:0]) : 4'b0000;
  assign mem_wdata   = hwdata;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scr1_ahb_sram_bridge.sv
// Bench for scr1_ahb_sram_bridge: directed vector table, pipelined and reset
// sequences, and random transfers against a byte-addressed reference memory.
module tb_scr1_ahb_sram_bridge;
  import scr1_ahb_sram_pkg::*;

  localparam int AW      = 20;
  localparam int STALL_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall_pattern;
  logic [1:0]         htrans;
  logic [31:0]        haddr;
  logic [2:0]         hsize;
  logic               hwrite;
  logic [31:0]        hwdata;
  logic               hready;
  logic [31:0]        hrdata;
  logic               hresp;
  logic               mem_req;
  logic               mem_we;
  logic [AW-3:0]      mem_addr;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata = 32'h0;
  state_e             dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  int req_cnt  = 0;

  logic [31:0] sram    [int];
  logic [7:0]  ref_mem [int];

  typedef struct {
    int          cycles;
    logic        err;
    logic        first_hready;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] maddr;
    int          reqs;
  } res_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] pat;
    logic        exp_err;
    int          exp_cyc;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  scr1_ahb_sram_bridge #(.AW(AW), .STALL_W(STALL_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_pattern (stall_pattern),
    .htrans        (htrans),
    .haddr         (haddr),
    .hsize         (hsize),
    .hwrite        (hwrite),
    .hwdata        (hwdata),
    .hready        (hready),
    .hrdata        (hrdata),
    .hresp         (hresp),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .dbg_state_o   (dbg_state_o)
  );

  // SRAM: byte-masked write, read data valid the cycle after the request.
  always @(posedge clk) begin : sram_model
    logic [31:0] w;
    if (mem_req) begin
      w = sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : 32'h0;
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
        sram[int'(mem_addr)] = w;
      end else begin
        mem_rdata <= w;
      end
    end
  end

  always @(negedge clk) if (mem_req) req_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", n_errors);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    logic [31:0] w;
    int base;
    base = int'(addr) - int'(addr) % 4;
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = ref_mem.exists(base + i) ? ref_mem[base + i] : 8'h00;
    return w;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    int base, lane;
    base = int'(addr) - int'(addr) % 4;
    for (int i = 0; i < (1 << size); i++) begin
      lane = int'(addr) % 4 + i;
      ref_mem[base + lane] = wdata[lane*8 +: 8];
    end
  endtask

  function automatic logic is_illegal(input logic [31:0] addr, input logic [2:0] size);
    if (addr >= 32'(1 << AW)) return 1'b1;
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && addr % 2 != 0) return 1'b1;
    if (size == 3'd2 && addr % 4 != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [2:0] size);
    logic [3:0] be;
    be = 4'b0000;
    if (!is_illegal(addr, size))
      for (int i = 0; i < (1 << size); i++) be[int'(addr) % 4 + i] = 1'b1;
    return be;
  endfunction

  // Stalled cycles before ready: zeros ahead of the first one, MSB first.
  function automatic int lead_zeros(input logic [31:0] pat);
    logic [31:0] p;
    p = (pat == 32'h0) ? 32'hFFFF_FFFF : pat;
    for (int k = 0; k < 32; k++) if (p[31-k]) return k;
    return 0;
  endfunction

  // ---------------- driver / scoreboard tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [31:0] pat, output res_t r);
    int req0;
    stall_pattern = pat;
    htrans = HTRANS_NONSEQ;
    haddr  = addr;
    hsize  = size;
    hwrite = wr;
    req0   = req_cnt;
    tick();
    htrans = HTRANS_IDLE;
    hwdata = wdata;
    r.cycles = 0;
    r.err = 1'b1;
    r.first_hready = 1'bx;
    r.rdata = 32'h0;
    r.be = 4'b0000;
    r.maddr = 32'hFFFF_FFFF;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      r.cycles++;
      if (c == 0) r.first_hready = hready;
      if (!hresp) r.err = 1'b0;
      if (mem_req) begin
        r.be    = mem_be;
        r.maddr = 32'(mem_addr);
      end
      if (hready) begin
        r.rdata = hrdata;
        break;
      end
      tick();
    end
    tick();
    r.reqs = req_cnt - req0;
  endtask

  task automatic judge(input string tag, input logic wr, input logic [31:0] addr, input res_t r,
                       input logic e_err, input int e_cyc, input logic [3:0] e_be, input logic [31:0] e_rdata);
    check({tag, " hresp"}, 32'(r.err), 32'(e_err));
    check({tag, " cycles"}, r.cycles, e_cyc);
    check({tag, " first_hready"}, 32'(r.first_hready), 32'(e_cyc == 1));
    check({tag, " mem_req_count"}, r.reqs, e_err ? 0 : 1);
    check({tag, " mem_be"}, 32'(r.be), 32'(e_be));
    if (!e_err) check({tag, " mem_addr"}, r.maddr, addr >> 2);
    if (!e_err && !wr) check({tag, " hrdata"}, r.rdata, e_rdata);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    res_t r;
    logic [31:0] pdata [3];
    int req0;

    rst = 1'b1;
    htrans = HTRANS_IDLE;
    haddr = 32'h0;
    hsize = HSIZE_BYTE;
    hwrite = 1'b0;
    hwdata = 32'h0;
    stall_pattern = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("reset hready", 32'(hready), 32'h1);
    check("reset hresp", 32'(hresp), 32'h0);
    check("reset hrdata", hrdata, 32'h0);
    check("reset mem_req", 32'(mem_req), 32'h0);
    check("reset mem_we", 32'(mem_we), 32'h0);
    check("reset mem_be", 32'(mem_be), 32'h0);
    check("reset state", 32'(dbg_state_o), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    //            wr    addr           size  wdata          pattern        err   cyc be       rdata
    vecs.push_back('{1'b1, 32'h0000_0100, 3'd2, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 1,  4'b1111, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'hFFFF_FFFF, 1'b0, 2,  4'b1111, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 32'h0000_0203, 3'd0, 32'hAB00_0000, 32'hFFFF_FFFF, 1'b0, 1,  4'b1000, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0200, 3'd2, 32'h0,         32'hFFFF_FFFF, 1'b0, 2,  4'b1111, 32'hAB00_0000});
    vecs.push_back('{1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'hA000_0000, 1'b0, 2,  4'b1111, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'h5000_0000, 1'b0, 3,  4'b1111, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 32'h0000_0102, 3'd1, 32'h1234_0000, 32'h0000_0000, 1'b0, 1,  4'b1100, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'h0000_0000, 1'b0, 2,  4'b1111, 32'h1234_BEEF});
    vecs.push_back('{1'b0, 32'h0000_0101, 3'd1, 32'h0,         32'hFFFF_FFFF, 1'b1, 2,  4'b0000, 32'h0});
    vecs.push_back('{1'b0, 32'h0010_0000, 3'd2, 32'h0,         32'hFFFF_FFFF, 1'b1, 2,  4'b0000, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0000, 3'd3, 32'h0,         32'hFFFF_FFFF, 1'b1, 2,  4'b0000, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0006, 3'd2, 32'h5555_5555, 32'hFFFF_FFFF, 1'b1, 2,  4'b0000, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0010, 3'd2, 32'h1122_3344, 32'h0000_0001, 1'b0, 32, 4'b1111, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0011, 3'd0, 32'h0,         32'h4000_0000, 1'b0, 3,  4'b0010, 32'h1122_3344});

    foreach (vecs[i]) begin
      do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, vecs[i].pat, r);
      judge($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, r,
            vecs[i].exp_err, vecs[i].exp_cyc, vecs[i].exp_be, vecs[i].exp_rdata);
      if (vecs[i].wr && !vecs[i].exp_err) ref_write(vecs[i].addr, vecs[i].size, vecs[i].wdata);
    end

    // Back-to-back NONSEQ writes: one SRAM write per cycle, no idle bubble.
    pdata[0] = 32'hCAFE_0000;
    pdata[1] = 32'hCAFE_0004;
    pdata[2] = 32'hCAFE_0008;
    stall_pattern = 32'hFFFF_FFFF;
    req0 = req_cnt;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    haddr  = 32'h0;
    tick();
    for (int k = 0; k < 3; k++) begin
      hwdata = pdata[k];
      if (k < 2) haddr = 32'((k + 1) * 4);
      else htrans = HTRANS_IDLE;
      @(negedge clk);
      check($sformatf("pipe%0d hready", k), 32'(hready), 32'h1);
      check($sformatf("pipe%0d mem_req", k), 32'(mem_req), 32'h1);
      check($sformatf("pipe%0d mem_we", k), 32'(mem_we), 32'h1);
      check($sformatf("pipe%0d mem_addr", k), 32'(mem_addr), 32'(k));
      check($sformatf("pipe%0d mem_wdata", k), mem_wdata, pdata[k]);
      ref_write(32'(k * 4), 3'd2, pdata[k]);
      tick();
    end
    check("pipe mem_req_count", req_cnt - req0, 3);

    // Random transfers scored against the byte-level reference memory.
    for (int t = 0; t < 40; t++) begin
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] a, d, pat;
      logic        ill;
      wr = 1'($urandom_range(0, 1));
      sz = (t % 8 == 7) ? 3'd3 : 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 9) == 0) a = a + 32'(1 << AW) - 32'd256 + 32'($urandom_range(0, 1)) * 32'd256;
      d = $urandom;
      case ($urandom_range(0, 3))
        0:       pat = 32'h0;
        1:       pat = 32'hFFFF_FFFF;
        default: pat = $urandom;
      endcase
      ill = is_illegal(a, sz);
      do_xfer(wr, a, sz, d, pat, r);
      judge($sformatf("rnd%0d", t), wr, a, r, ill,
            ill ? 2 : (lead_zeros(pat) + (wr ? 1 : 2)), exp_be(a, sz), ref_read(a));
      if (wr && !ill) ref_write(a, sz, d);
    end

    // Reset in the middle of a stalled read aborts it cleanly.
    stall_pattern = 32'h0000_0001;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
    haddr  = 32'h0000_0100;
    tick();
    htrans = HTRANS_IDLE;
    tick();
    @(negedge clk);
    check("rstmid wait hready", 32'(hready), 32'h0);
    #2;
    rst = 1'b1;
    req0 = req_cnt;
    #1;
    check("rstmid hready", 32'(hready), 32'h1);
    check("rstmid hresp", 32'(hresp), 32'h0);
    check("rstmid mem_req", 32'(mem_req), 32'h0);
    check("rstmid hrdata", hrdata, 32'h0);
    repeat (3) @(negedge clk);
    check("rstmid no mem_req", req_cnt - req0, 0);
    rst = 1'b0;
    tick();
    do_xfer(1'b0, 32'h0000_0008, 3'd2, 32'h0, 32'hFFFF_FFFF, r);
    judge("after_rst", 1'b0, 32'h0000_0008, r, 1'b0, 2, 4'b1111, ref_read(32'h0000_0008));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
